// File: rtl/l1d_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache, one 32-bit word per line.
// Initiator on the memory controller's L1D port; all port outputs are registered or state-decoded.
module l1d_cache #(
  parameter int LINES       = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic        invalidate,
  output logic [31:0] cpu_read_data,
  output logic        cpu_ready,
  output logic [31:0] l1d_address,
  output logic [31:0] l1d_input_data,
  output logic        l1d_mem_read,
  output logic        l1d_mem_write,
  input  logic [31:0] output_data,
  input  logic        stall_l1d,
  output logic [2:0]  dbg_state
);

  // Handshake: the CPU holds cpu_read/cpu_write stable until the one-cycle cpu_ready pulse;
  // toward memory, a strobe is accepted in a cycle where stall_l1d is low at the clock edge.

  localparam int IB = $clog2(LINES);
  localparam int TB = 30 - IB;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ_REQ  = 3'd1,
    READ_WAIT = 3'd2,
    WRITE_REQ = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [LINES-1:0] valid;
  logic [TB-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic [CW-1:0]    cnt;

  logic [IB-1:0] cpu_idx, req_idx;
  logic [TB-1:0] cpu_tag, req_tag;
  logic          cpu_hit, req_hit, fill_now;
  logic          cpu_byte_unused;

  assign cpu_idx         = cpu_address[IB+1:2];
  assign cpu_tag         = cpu_address[31:IB+2];
  assign req_idx         = l1d_address[IB+1:2];
  assign req_tag         = l1d_address[31:IB+2];
  assign cpu_hit         = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign req_hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill_now        = (state == READ_WAIT) && (cnt == CW'(1));
  assign cpu_byte_unused = ^cpu_address[1:0];

  assign l1d_mem_read  = (state == READ_REQ) || (state == READ_WAIT);
  assign l1d_mem_write = (state == WRITE_REQ);
  assign cpu_ready     = (state == DONE);
  assign dbg_state     = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (invalidate)     state_nx = IDLE;
        else if (cpu_write) state_nx = WRITE_REQ;
        else if (cpu_read)  state_nx = cpu_hit ? DONE : READ_REQ;
      end
      READ_REQ:  if (!stall_l1d) state_nx = READ_WAIT;
      READ_WAIT: if (fill_now)   state_nx = DONE;
      WRITE_REQ: if (!stall_l1d) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      valid          <= '0;
      cnt            <= '0;
      cpu_read_data  <= '0;
      l1d_address    <= '0;
      l1d_input_data <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (invalidate) begin
            valid <= '0;
          end else if (cpu_write) begin
            l1d_address    <= {cpu_address[31:2], 2'b00};
            l1d_input_data <= cpu_write_data;
          end else if (cpu_read) begin
            if (cpu_hit) cpu_read_data <= data_mem[cpu_idx];
            else         l1d_address   <= {cpu_address[31:2], 2'b00};
          end
        end
        READ_REQ: if (!stall_l1d) cnt <= CW'(MEM_LATENCY);
        READ_WAIT: begin
          cnt <= cnt - CW'(1);
          if (fill_now) begin
            valid[req_idx] <= 1'b1;
            cpu_read_data  <= output_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge clock) begin
    if (fill_now) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= output_data;
    end else if ((state == WRITE_REQ) && !stall_l1d && req_hit) begin
      data_mem[req_idx] <= l1d_input_data;
    end
  end

endmodule

// File: tb/tb_l1d_cache.sv
// Directed bench for l1d_cache: table of CPU requests with hand-computed latency/data,
// plus a hand-written reset-during-miss sequence. A small word memory answers the L1D port.
module tb_l1d_cache;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cpu_address = '0;
  logic [31:0] cpu_write_data = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic        invalidate = 1'b0;
  logic [31:0] cpu_read_data;
  logic        cpu_ready;
  logic [31:0] l1d_address;
  logic [31:0] l1d_input_data;
  logic        l1d_mem_read;
  logic        l1d_mem_write;
  logic [31:0] output_data;
  logic        stall_l1d = 1'b0;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  l1d_cache #(.LINES(16), .MEM_LATENCY(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .invalidate(invalidate),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
    .l1d_address(l1d_address), .l1d_input_data(l1d_input_data),
    .l1d_mem_read(l1d_mem_read), .l1d_mem_write(l1d_mem_write),
    .output_data(output_data), .stall_l1d(stall_l1d), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Backing memory: 64 words, default contents 0x1000_0000 + byte address.
  logic [31:0] bmem [64];
  assign output_data = l1d_mem_read ? bmem[l1d_address[7:2]] : 32'h0;
  always @(posedge clock) begin
    if (l1d_mem_write && !stall_l1d) bmem[l1d_address[7:2]] <= l1d_input_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        inv;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] exp_data;
    int          exp_lat;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_req(input string tag, input vec_t v);
    int          lat;
    int          stall_left;
    logic        done, seen_rd, seen_wr, seen_strobe;
    logic [31:0] first_addr, wr_addr, wr_data;
    lat = 0; done = 0; seen_rd = 0; seen_wr = 0; seen_strobe = 0;
    first_addr = '0; wr_addr = '0; wr_data = '0;
    stall_left = v.stalls;
    @(negedge clock);
    if (v.inv) begin
      invalidate = 1'b1;
      @(negedge clock);
      invalidate = 1'b0;
      chk({tag, "_inv_idle"}, {28'h0, cpu_ready, dbg_state}, 32'h0);
    end
    cpu_address = v.addr;
    cpu_write_data = v.wdata;
    cpu_read = v.rd;
    cpu_write = v.wr;
    stall_l1d = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      lat++;
      if (l1d_mem_read && l1d_mem_write) chk({tag, "_both_strobes"}, 32'h1, 32'h0);
      if (l1d_mem_read || l1d_mem_write) begin
        if (!seen_strobe) first_addr = l1d_address;
        else if (l1d_address !== first_addr) chk({tag, "_addr_stable"}, l1d_address, first_addr);
        seen_strobe = 1'b1;
        if (l1d_mem_read) seen_rd = 1'b1;
        if (l1d_mem_write) begin
          seen_wr = 1'b1;
          wr_addr = l1d_address;
          wr_data = l1d_input_data;
        end
        stall_l1d = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else begin
        stall_l1d = 1'b0;
      end
      if (cpu_ready) begin
        done = 1'b1;
        break;
      end
    end
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    stall_l1d = 1'b0;
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
    chk({tag, "_lat"}, lat, v.exp_lat);
    chk({tag, "_mem_rd"}, {31'h0, seen_rd}, {31'h0, v.exp_rd});
    chk({tag, "_mem_wr"}, {31'h0, seen_wr}, {31'h0, v.exp_wr});
    if (v.exp_wr) begin
      chk({tag, "_wr_addr"}, wr_addr, {v.addr[31:2], 2'b00});
      chk({tag, "_wr_data"}, wr_data, v.wdata);
    end
    if (v.rd && !v.wr) begin
      chk({tag, "_rdata"}, cpu_read_data, v.exp_data);
      @(negedge clock);
      chk({tag, "_rdata_hold"}, cpu_read_data, v.exp_data);
      chk({tag, "_ready_pulse"}, {31'h0, cpu_ready}, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) bmem[i] = 32'h1000_0000 + (i << 2);
    bmem[32] = 32'hDEADBEEF;

    //          inv   rd    wr    addr          wdata         st  exp_data      lat rd    wr
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,        0, 32'hDEADBEEF, 3, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,        0, 32'hDEADBEEF, 1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h12345678, 0, 32'h0,        2, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0083, 32'h0,        0, 32'h12345678, 1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0084, 32'hA5A5A5A5, 0, 32'h0,        2, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0084, 32'h0,        0, 32'hA5A5A5A5, 3, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_00C0, 32'h0,        3, 32'h100000C0, 6, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,        0, 32'h12345678, 3, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_00C0, 32'h0,        0, 32'h100000C0, 3, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFEF00D, 0, 32'h0,        2, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,        0, 32'hCAFEF00D, 3, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,        0, 32'hCAFEF00D, 1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,        0, 32'hCAFEF00D, 3, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0BADF00D, 2, 32'h0,        4, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,        0, 32'h0BADF00D, 1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0000_0084, 32'h0,        0, 32'hA5A5A5A5, 3, 1'b1, 1'b0};

    #12;
    chk("rst_ready", {31'h0, cpu_ready}, 32'h0);
    chk("rst_strobes", {30'h0, l1d_mem_read, l1d_mem_write}, 32'h0);
    chk("rst_rdata", cpu_read_data, 32'h0);
    chk("rst_addr", l1d_address, 32'h0);
    chk("rst_wdata", l1d_input_data, 32'h0);
    chk("rst_state", {29'h0, dbg_state}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) run_req($sformatf("v%0d", i), vecs[i]);

    // Reset asserted while the miss sits in READ_WAIT.
    @(negedge clock);
    cpu_address = 32'h0000_0088;
    cpu_read = 1'b1;
    @(negedge clock);
    chk("rm_read_req", {31'h0, l1d_mem_read}, 32'h1);
    @(negedge clock);
    chk("rm_in_wait", {29'h0, dbg_state}, 32'h2);
    #1 reset_n = 1'b0;
    #1;
    chk("rm_mem_read_drop", {31'h0, l1d_mem_read}, 32'h0);
    chk("rm_ready_low", {31'h0, cpu_ready}, 32'h0);
    chk("rm_addr_clear", l1d_address, 32'h0);
    cpu_read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    run_req("rm_reread", '{1'b0, 1'b1, 1'b0, 32'h0000_0088, 32'h0, 0, 32'h10000088, 3, 1'b1, 1'b0});
    run_req("rm_line80", '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, 32'h12345678, 3, 1'b1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
